demux_sel_sequencer: RTL and testbench

//  Upstream driver for the 1-to-8 demultiplexer. Steps the select code S across

---
 rtl/demux_sel_sequencer.sv | 119 +++++++++++
 tb/tb_demux_sel_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// Select/enable sequencer for a 1-to-8 demux: walks S over the enabled channels,
// holding each for a programmable dwell, in one-shot or continuous mode.
module demux_sel_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               ABORT,
    input  logic               MODE,
    input  logic [7:0]         CH_MASK,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic               D_IN,
    output logic               D,
    output logic [2:0]         S,
    output logic               E,
    output logic               BUSY,
    output logic               DONE
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_last;
    logic               nxt_valid;
    logic [2:0]         nxt_ch;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // A latched dwell of zero behaves as one cycle per channel.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_valid = 1'b0;
        nxt_ch    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > S)) begin
                nxt_valid = 1'b1;
                nxt_ch    = 3'(i);
            end
        end
    end

    assign D = D_IN & E;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            mask_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            cnt     <= '0;
            S       <= 3'd0;
            E       <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !ABORT) begin
                        if (CH_MASK != 8'd0) begin
                            mask_q  <= CH_MASK;
                            dwell_q <= DWELL;
                            mode_q  <= MODE;
                            S       <= lowest_bit(CH_MASK);
                            E       <= 1'b1;
                            BUSY    <= 1'b1;
                            cnt     <= '0;
                            state   <= SCAN;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (ABORT) begin
                        E     <= 1'b0;
                        BUSY  <= 1'b0;
                        S     <= 3'd0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == dwell_last) begin
                        cnt <= '0;
                        if (nxt_valid) begin
                            S <= nxt_ch;
                        end else if (mode_q) begin
                            S <= lowest_bit(mask_q);
                        end else begin
                            E     <= 1'b0;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            S     <= 3'd0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer: directed and randomized scans
// compared against a per-cycle channel list built from the mask and dwell.
module tb_demux_sel_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic       MODE;
    logic [7:0] CH_MASK;
    logic [7:0] DWELL;
    logic       D_IN;
    logic       D;
    logic [2:0] S;
    logic       E;
    logic       BUSY;
    logic       DONE;

    int tests = 0;
    int fails = 0;

    demux_sel_sequencer #(.DWELL_W(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .ABORT   (ABORT),
        .MODE    (MODE),
        .CH_MASK (CH_MASK),
        .DWELL   (DWELL),
        .D_IN    (D_IN),
        .D       (D),
        .S       (S),
        .E       (E),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, ".E"}, 8'(E), 8'd0);
        check({tag, ".BUSY"}, 8'(BUSY), 8'd0);
        check({tag, ".S"}, 8'(S), 8'd0);
        check({tag, ".DONE"}, 8'(DONE), 8'(exp_done));
        D_IN = 1'b1;
        #1;
        check({tag, ".D"}, 8'(D), 8'd0);
    endtask

    // Reference: list of channels S must show, one entry per scanning cycle.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] dw, input logic md,
                            input int ncyc, input bit rand_d, input bit disturb);
        int eff;
        int len;
        int q[$];
        logic d_val;
        eff = (dw == 8'd0) ? 1 : int'(dw);
        do begin
            for (int ch = 0; ch < 8; ch++)
                if (m[ch])
                    for (int k = 0; k < eff; k++) q.push_back(ch);
        end while (md && q.size() < ncyc);
        len = md ? ncyc : q.size();

        CH_MASK = m;
        DWELL   = dw;
        MODE    = md;
        START   = 1'b1;
        step();
        START = 1'b0;
        for (int j = 0; j < len; j++) begin
            check("scan.S", 8'(S), 8'(q[j]));
            check("scan.E", 8'(E), 8'd1);
            check("scan.BUSY", 8'(BUSY), 8'd1);
            check("scan.DONE", 8'(DONE), 8'd0);
            d_val = rand_d ? 1'($urandom) : 1'b1;
            D_IN  = d_val;
            #1;
            check("scan.D", 8'(D), 8'(d_val));
            check("scan.I", 8'(D) << S, 8'(d_val) << q[j]);
            if (disturb) begin
                CH_MASK = 8'($urandom);
                DWELL   = 8'($urandom);
                MODE    = 1'($urandom);
                START   = 1'($urandom);
            end
            step();
        end
        START   = 1'b0;
        CH_MASK = 8'd0;
        if (md) begin
            ABORT = 1'b1;
            step();
            ABORT = 1'b0;
            check_idle("abort", 1'b0);
            step();
            check_idle("abort_after", 1'b0);
        end else begin
            check_idle("pass_end", 1'b1);
            step();
            check_idle("pass_end_after", 1'b0);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; MODE = 1'b0;
        CH_MASK = 8'd0; DWELL = 8'd1; D_IN = 1'b0;
        #12;
        check_idle("reset", 1'b0);
        RST = 1'b0;
        step();

        // One-shot walk over all channels, D_IN held high.
        run_scan(8'hFF, 8'd1, 1'b0, 0, 1'b0, 1'b0);
        // Sparse mask with dwell 3.
        run_scan(8'hA5, 8'd3, 1'b0, 0, 1'b1, 1'b0);
        // Continuous two-channel scan, then abort.
        run_scan(8'h81, 8'd2, 1'b1, 12, 1'b1, 1'b0);
        // Dwell 0 behaves as 1, with mid-scan input disturbance.
        run_scan(8'h3C, 8'd0, 1'b0, 0, 1'b1, 1'b1);
        // Single-bit mask in continuous mode stays on one channel.
        run_scan(8'h10, 8'd1, 1'b1, 9, 1'b1, 1'b1);

        // Empty mask: DONE pulse only.
        CH_MASK = 8'd0; START = 1'b1;
        step();
        START = 1'b0;
        check_idle("empty_mask", 1'b1);
        step();
        check_idle("empty_mask_after", 1'b0);

        // START and ABORT together in IDLE: no scan.
        CH_MASK = 8'hFF; START = 1'b1; ABORT = 1'b1;
        step();
        START = 1'b0; ABORT = 1'b0;
        check_idle("start_abort", 1'b0);
        step();
        check_idle("start_abort_after", 1'b0);

        // ABORT coinciding with the last cycle of a one-shot pass suppresses DONE.
        CH_MASK = 8'h01; DWELL = 8'd1; MODE = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        check("abort_end.E", 8'(E), 8'd1);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        check_idle("abort_end", 1'b0);

        // Asynchronous reset in the middle of a continuous scan.
        CH_MASK = 8'hF0; DWELL = 8'd4; MODE = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        check("pre_rst.E", 8'(E), 8'd1);
        #2;
        RST = 1'b1;
        #1;
        check_idle("async_rst", 1'b0);
        RST = 1'b0;
        step();
        check_idle("async_rst_after", 1'b0);

        // Randomized one-shot and continuous scans.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] m;
            m = 8'($urandom_range(1, 255));
            run_scan(m, 8'($urandom_range(0, 4)), 1'(r % 2), $urandom_range(5, 30), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
